// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter: FSM state encoding,
// requester ids and default RAM geometry.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select between requesters A and B.
// RAM_ARB_FIXED_PRIO_EN: A always wins ties and no last-grant input exists.
module ram_arb_pick
    import ram_arb_pkg::*;
(
`ifndef RAM_ARB_FIXED_PRIO_EN
    input  logic last,
`endif
    input  logic a_req,
    input  logic b_req,
    output logic grant,
    output logic any
);

    always_comb begin
        any   = a_req | b_req;
        grant = PORT_A;
        if (a_req && b_req) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            grant = PORT_A;
`else
            // Tie goes to whichever port was not granted most recently.
            grant = (last == PORT_A) ? PORT_B : PORT_A;
`endif
        end else if (b_req) begin
            grant = PORT_B;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for a synchronous RAM with registered read data.
// RAM_ARB_FIXED_PRIO_EN selects fixed A-first priority instead of round-robin.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_wren,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_done,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_wren,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_done,
    output logic [DATA_W-1:0] b_rdata,
    output logic              busy,
    output logic              ram_en_n,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_wraddress,
    output logic [ADDR_W-1:0] ram_rdaddress,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q
);

    state_t state;
    logic   win_id;
    logic   win_wren;
    logic   pick_id;
    logic   pick_any;

`ifdef RAM_ARB_FIXED_PRIO_EN
    ram_arb_pick u_pick (
        .a_req (a_req),
        .b_req (b_req),
        .grant (pick_id),
        .any   (pick_any)
    );
`else
    logic last;

    ram_arb_pick u_pick (
        .last  (last),
        .a_req (a_req),
        .b_req (b_req),
        .grant (pick_id),
        .any   (pick_any)
    );
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            win_id        <= PORT_A;
            win_wren      <= 1'b0;
            busy          <= 1'b0;
            ram_en_n      <= 1'b1;
            ram_wren      <= 1'b0;
            ram_wraddress <= '0;
            ram_rdaddress <= '0;
            ram_data      <= '0;
            a_done        <= 1'b0;
            b_done        <= 1'b0;
            a_rdata       <= '0;
            b_rdata       <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last          <= PORT_B;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state         <= ISSUE;
                        busy          <= 1'b1;
                        win_id        <= pick_id;
                        win_wren      <= pick_id ? b_wren : a_wren;
                        ram_en_n      <= 1'b0;
                        ram_wren      <= pick_id ? b_wren : a_wren;
                        ram_wraddress <= pick_id ? b_addr : a_addr;
                        ram_rdaddress <= pick_id ? b_addr : a_addr;
                        ram_data      <= pick_id ? b_wdata : a_wdata;
`ifndef RAM_ARB_FIXED_PRIO_EN
                        last          <= pick_id;
`endif
                    end
                end
                ISSUE: begin
                    state    <= RESP;
                    ram_en_n <= 1'b1;
                    ram_wren <= 1'b0;
                end
                RESP: begin
                    // ram_q carries the read word in this cycle only.
                    state  <= DONE;
                    a_done <= (win_id == PORT_A);
                    b_done <= (win_id == PORT_B);
                    if (!win_wren) begin
                        if (win_id == PORT_A) a_rdata <= ram_q;
                        else                  b_rdata <= ram_q;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    a_done <= 1'b0;
                    b_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized
// two-requester traffic against a transaction-level model with a RAM behind it.
module tb_ram_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       a_req, a_wren, b_req, b_wren;
    logic [3:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_done, b_done, busy, ram_en_n, ram_wren;
    logic [7:0] a_rdata, b_rdata, ram_data, ram_q;
    logic [3:0] ram_wraddress, ram_rdaddress;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state
    logic [7:0] ref_mem [16];
    logic [7:0] exp_a, exp_b;
    logic       m_last;

    // RAM that the arbiter drives
    logic [7:0] tb_mem [16];

    ram_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .a_req         (a_req),
        .a_wren        (a_wren),
        .a_addr        (a_addr),
        .a_wdata       (a_wdata),
        .a_done        (a_done),
        .a_rdata       (a_rdata),
        .b_req         (b_req),
        .b_wren        (b_wren),
        .b_addr        (b_addr),
        .b_wdata       (b_wdata),
        .b_done        (b_done),
        .b_rdata       (b_rdata),
        .busy          (busy),
        .ram_en_n      (ram_en_n),
        .ram_wren      (ram_wren),
        .ram_wraddress (ram_wraddress),
        .ram_rdaddress (ram_rdaddress),
        .ram_data      (ram_data),
        .ram_q         (ram_q)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!ram_en_n) begin
            if (ram_wren) tb_mem[ram_wraddress] <= ram_data;
            else          ram_q <= tb_mem[ram_rdaddress];
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic port, input logic req, input logic wren,
                         input logic [3:0] addr, input logic [7:0] data);
        if (port == 1'b0) begin
            a_req = req; a_wren = wren; a_addr = addr; a_wdata = data;
        end else begin
            b_req = req; b_wren = wren; b_addr = addr; b_wdata = data;
        end
    endtask

    function automatic logic model_winner(input logic ar, input logic br);
        if (ar && !br) return 1'b0;
        if (br && !ar) return 1'b1;
`ifdef RAM_ARB_FIXED_PRIO_EN
        return 1'b0;
`else
        return (m_last == 1'b0) ? 1'b1 : 1'b0;
`endif
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
        m_last = 1'b1;
        exp_a  = 8'h00;
        exp_b  = 8'h00;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
        apply_reset();
        tests_run++;
        if ({busy, ram_en_n, ram_wren, a_done, b_done} !== 5'b01000) begin
            tests_failed++;
            $display("FAIL reset_ctrl got=%b want=01000", {busy, ram_en_n, ram_wren, a_done, b_done});
        end
        tests_run++;
        if ({a_rdata, b_rdata, ram_wraddress, ram_rdaddress, ram_data} !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_data got=%h want=0", {a_rdata, b_rdata, ram_wraddress, ram_rdaddress, ram_data});
        end
    endtask

    task automatic test_write_read();
        drive(1'b0, 1'b1, 1'b1, 4'd3, 8'h5A);
        tick();
        tests_run++;
        if ({busy, ram_en_n, ram_wren, ram_wraddress, ram_rdaddress, ram_data} !== {1'b1, 1'b0, 1'b1, 4'd3, 4'd3, 8'h5A}) begin
            tests_failed++;
            $display("FAIL wr_issue got=%h want=%h", {busy, ram_en_n, ram_wren, ram_wraddress, ram_rdaddress, ram_data},
                     {1'b1, 1'b0, 1'b1, 4'd3, 4'd3, 8'h5A});
        end
        tick();
        tests_run++;
        if ({ram_en_n, ram_wren, a_done} !== 3'b100) begin
            tests_failed++;
            $display("FAIL wr_resp got=%b want=100", {ram_en_n, ram_wren, a_done});
        end
        tick();
        ref_mem[3] = 8'h5A;
        m_last     = 1'b0;
        tests_run++;
        if ({a_done, b_done, a_rdata} !== {2'b10, 8'h00}) begin
            tests_failed++;
            $display("FAIL wr_done got=%h want=200", {a_done, b_done, a_rdata});
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        tick();
        tests_run++;
        if ({busy, a_done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL wr_idle got=%b want=00", {busy, a_done});
        end
        drive(1'b1, 1'b1, 1'b0, 4'd3, 8'd0);
        tick();
        tests_run++;
        if ({ram_en_n, ram_wren, ram_rdaddress} !== {2'b00, 4'd3}) begin
            tests_failed++;
            $display("FAIL rd_issue got=%h want=03", {ram_en_n, ram_wren, ram_rdaddress});
        end
        tick();
        tick();
        exp_b  = ref_mem[3];
        m_last = 1'b1;
        tests_run++;
        if ({a_done, b_done, a_rdata, b_rdata} !== {2'b01, exp_a, exp_b}) begin
            tests_failed++;
            $display("FAIL rd_done got=%h want=%h", {a_done, b_done, a_rdata, b_rdata}, {2'b01, exp_a, exp_b});
        end
        drive(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
        tick();
    endtask

    task automatic test_fill();
        logic       p;
        logic [7:0] d;
        for (int i = 0; i < 16; i++) begin
            p = i[0];
            d = 8'($urandom_range(0, 255));
            drive(p, 1'b1, 1'b1, 4'(i), d);
            tick();
            tick();
            tick();
            ref_mem[i] = d;
            m_last     = p;
            tests_run++;
            if ({a_done, b_done, a_rdata, b_rdata} !== {~p, p, exp_a, exp_b}) begin
                tests_failed++;
                $display("FAIL fill_%0d got=%h want=%h", i, {a_done, b_done, a_rdata, b_rdata}, {~p, p, exp_a, exp_b});
            end
            drive(p, 1'b0, 1'b0, 4'd0, 8'd0);
            tick();
        end
    endtask

    task automatic test_tie();
        logic w;
        apply_reset();
        drive(1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
        drive(1'b1, 1'b1, 1'b0, 4'd1, 8'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            tick();
            tick();
            w      = model_winner(1'b1, 1'b1);
            m_last = w;
            if (w) exp_b = ref_mem[1];
            else   exp_a = ref_mem[0];
            tests_run++;
            if ({a_done, b_done, a_rdata, b_rdata} !== {~w, w, exp_a, exp_b}) begin
                tests_failed++;
                $display("FAIL tie_%0d got=%h want=%h", k, {a_done, b_done, a_rdata, b_rdata}, {~w, w, exp_a, exp_b});
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 1'b0, 4'd5, 8'd0);
        tick();
        tick();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        tick();
        reset  = 1'b0;
        m_last = 1'b1;
        exp_a  = 8'h00;
        exp_b  = 8'h00;
        tests_run++;
        if ({a_done, b_done, busy, ram_en_n, a_rdata, b_rdata} !== {4'b0001, 16'h0000}) begin
            tests_failed++;
            $display("FAIL rst_mid got=%h want=10000", {a_done, b_done, busy, ram_en_n, a_rdata, b_rdata});
        end
        tick();
        tests_run++;
        if ({a_done, b_done, busy} !== 3'b000) begin
            tests_failed++;
            $display("FAIL rst_mid_late got=%b want=000", {a_done, b_done, busy});
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 4'(i), 8'(8'hF0 + i));
            tick();
            tick();
            tick();
            ref_mem[i] = 8'(8'hF0 + i);
            m_last     = 1'b1;
            drive(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            tick();
            tests_run++;
            if (a_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_early_%0d got=%b want=0", k, a_done);
            end
            tick();
            exp_a  = ref_mem[k];
            m_last = 1'b0;
            tests_run++;
            if ({a_done, a_rdata} !== {1'b1, 8'(8'hF0 + k)}) begin
                tests_failed++;
                $display("FAIL b2b_%0d got=%h want=%h", k, {a_done, a_rdata}, {1'b1, 8'(8'hF0 + k)});
            end
            if (k < 2) a_addr = 4'(k + 1);
            else       drive(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
            tick();
        end
    endtask

    task automatic test_random();
        logic       ap, bp, aw, bw, w, ww;
        logic [3:0] aa, ba, wa;
        logic [7:0] ad, bd, wd;
        ap = 1'b0; bp = 1'b0;
        aw = 1'b0; bw = 1'b0; aa = 4'd0; ba = 4'd0; ad = 8'd0; bd = 8'd0;
        for (int it = 0; it < 60; it++) begin
            if (!ap && $urandom_range(0, 2) != 0) begin
                ap = 1'b1; aw = 1'($urandom_range(0, 1));
                aa = 4'($urandom_range(0, 15)); ad = 8'($urandom_range(0, 255));
                drive(1'b0, 1'b1, aw, aa, ad);
            end
            if (!bp && $urandom_range(0, 2) != 0) begin
                bp = 1'b1; bw = 1'($urandom_range(0, 1));
                ba = 4'($urandom_range(0, 15)); bd = 8'($urandom_range(0, 255));
                drive(1'b1, 1'b1, bw, ba, bd);
            end
            if (!ap && !bp) begin
                tick();
                tests_run++;
                if ({busy, ram_en_n} !== 2'b01) begin
                    tests_failed++;
                    $display("FAIL rnd_idle_%0d got=%b want=01", it, {busy, ram_en_n});
                end
                continue;
            end
            w  = model_winner(ap, bp);
            ww = w ? bw : aw;
            wa = w ? ba : aa;
            wd = w ? bd : ad;
            tick();
            tests_run++;
            if ({ram_en_n, ram_wren, ram_wraddress, ram_rdaddress, ram_data} !== {1'b0, ww, wa, wa, wd}) begin
                tests_failed++;
                $display("FAIL rnd_issue_%0d got=%h want=%h", it, {ram_en_n, ram_wren, ram_wraddress, ram_rdaddress, ram_data},
                         {1'b0, ww, wa, wa, wd});
            end
            tick();
            tests_run++;
            if ({ram_en_n, ram_wren, a_done, b_done} !== 4'b1000) begin
                tests_failed++;
                $display("FAIL rnd_resp_%0d got=%b want=1000", it, {ram_en_n, ram_wren, a_done, b_done});
            end
            tick();
            m_last = w;
            if (ww)     ref_mem[wa] = wd;
            else if (w) exp_b = ref_mem[wa];
            else        exp_a = ref_mem[wa];
            tests_run++;
            if ({a_done, b_done, a_rdata, b_rdata} !== {~w, w, exp_a, exp_b}) begin
                tests_failed++;
                $display("FAIL rnd_done_%0d got=%h want=%h", it, {a_done, b_done, a_rdata, b_rdata}, {~w, w, exp_a, exp_b});
            end
            if (w) bp = 1'b0;
            else   ap = 1'b0;
            drive(w, 1'b0, 1'b0, 4'd0, 8'd0);
            tick();
            tests_run++;
            if ({busy, a_done, b_done} !== 3'b000) begin
                tests_failed++;
                $display("FAIL rnd_back_idle_%0d got=%b want=000", it, {busy, a_done, b_done});
            end
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_write_read();
        test_fill();
        test_tie();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
